// File: rtl/cwt_accumulator.sv
// cwt_accumulator: windowed TAPS-product sum with valid/ready output; ACC_SATURATE_EN clamps instead of wrapping
module cwt_accumulator #(
  parameter int BITS  = 16,
  parameter int TRANC = 8,
  parameter int TAPS  = 64,
  parameter int GUARD = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] acc_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            clear,
  output logic [BITS-1:0] acc_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            sat_flag,
  output logic            busy
);
  localparam int ACC_BITS = BITS + GUARD;
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [CW-1:0] LAST = CW'(TAPS - 1);
  if (TAPS < 1 || TAPS > (1 << GUARD) || GUARD < 1 || TRANC >= BITS) begin : g_bad_cfg
    $error("cwt_accumulator: illegal parameter combination");
  end
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_d;
  logic [ACC_BITS-1:0] sum, sum_d, base, fsum;
  logic [CW-1:0] count, count_d, count_base;
  logic [BITS-1:0] acc_out_d, res;
  logic sat_d, sat;
  assign in_ready = state != HOLD;
  assign out_valid = state == HOLD;
  assign busy = state == ACCUM;
  // IDLE starts a fresh window, so the running sum/count are ignored there
  assign base = state == IDLE ? '0 : sum;
  assign count_base = state == IDLE ? '0 : count;
  assign fsum = base + {{GUARD{acc_in[BITS-1]}}, acc_in};
`ifdef ACC_SATURATE_EN
  logic hi, lo;
  assign hi = ~fsum[ACC_BITS-1] & |fsum[ACC_BITS-2:BITS-1];
  assign lo = fsum[ACC_BITS-1] & ~&fsum[ACC_BITS-2:BITS-1];
  assign res = hi ? {1'b0, {(BITS-1){1'b1}}} : lo ? {1'b1, {(BITS-1){1'b0}}} : fsum[BITS-1:0];
  assign sat = hi | lo;
`else
  assign res = fsum[BITS-1:0];
  assign sat = 1'b0;
`endif
  always_comb begin
    state_d = state;
    sum_d = sum;
    count_d = count;
    acc_out_d = acc_out;
    sat_d = sat_flag;
    if (state == HOLD) begin
      if (out_ready) state_d = IDLE;
    end else if (clear) begin
      state_d = IDLE;
      sum_d = '0;
      count_d = '0;
    end else if (in_valid) begin
      sum_d = fsum;
      count_d = count_base + CW'(1);
      state_d = count_base == LAST ? HOLD : ACCUM;
      acc_out_d = count_base == LAST ? res : acc_out;
      sat_d = count_base == LAST ? sat : sat_flag;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sum <= '0;
      count <= '0;
      acc_out <= '0;
      sat_flag <= 1'b0;
    end else begin
      state <= state_d;
      sum <= sum_d;
      count <= count_d;
      acc_out <= acc_out_d;
      sat_flag <= sat_d;
    end
  end
endmodule

// File: doc/cwt_accumulator.md
# cwt_accumulator

Windowed signed fixed-point accumulator directly downstream of the CWT multiplier stage. It sums TAPS consecutive products (signal sample × wavelet coefficient) into one wavelet coefficient for the current scale and shift. It presents the result through a valid/ready handshake to the coefficient store. Products arrive in the same two's-complement Q format the multiplier emits (BITS wide, TRANC fractional bits), and the result leaves in that same format.

## Interface
- BITS, 16: sample/product/result width (two's complement).
- TRANC, 8: fractional bits; informational only, since accumulation is format-preserving.
- TAPS, 64: products per window; legal range 1 to 2^GUARD.
- GUARD, 6: extra accumulator bits; internal width ACC_BITS = BITS+GUARD.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- acc_in  in  BITS  product from the multiplier.
- in_valid  in  1  acc_in is valid this cycle.
- in_ready  out  1  block accepts acc_in this cycle.
- clear  in  1  synchronous abort: discard the partial window.
- acc_out  out  BITS  window sum, held stable while out_valid=1.
- out_valid  out  1  acc_out is valid.
- out_ready  in  1  consumer accepts acc_out.
- sat_flag  out  1  the current acc_out was clamped.
- busy  out  1  the window is partially accumulated (state ACCUM).

## Operation
- Reset values: state=IDLE, sum=0, count=0, acc_out=0, out_valid=0, sat_flag=0, busy=0. in_ready is 1 after reset.
- An accepted beat is in_valid & in_ready.
- IDLE (in_ready=1):
  - On a beat: sum ← sext(acc_in), count ← 1.
  - Next state is HOLD if TAPS==1, otherwise ACCUM.
- ACCUM (in_ready=1, busy=1):
  - On a beat: sum ← sum + sext(acc_in), count ← count+1.
  - When the beat is the TAPS-th, latch the result into acc_out and go to HOLD.
  - Cycles with no beat leave the state unchanged (bubbles allowed).
- HOLD (in_ready=0, out_valid=1): acc_out and sat_flag hold. When out_ready=1, go to IDLE and clear out_valid.
- Arithmetic:
  - sext means sign-extending BITS to ACC_BITS.
  - The sum never overflows internally, because TAPS ≤ 2^GUARD.
  - No rounding and no shift: a Q-format sum of Q-format values.
- Result formation (see Configuration): the final sum includes the last beat. It is computed combinationally in the cycle of that beat and registered.
- clear:
  - In IDLE or ACCUM: sum and count are zeroed and the state goes to IDLE. A beat in the same cycle is discarded (clear wins).
  - In HOLD: clear is ignored, so a completed result is never lost.
- rst mid-window or mid-HOLD: everything returns to reset values immediately. Partial and pending results are lost.

## Timing
- Latency: out_valid rises on the clock edge that accepts the TAPS-th beat, so it is visible the cycle after that beat.
- Throughput: one beat per cycle in ACCUM. There is at least one stall cycle (HOLD) per window, and HOLD lasts until out_ready. Peak rate is TAPS beats per TAPS+1 cycles.
- in_ready is a pure function of state (IDLE/ACCUM → 1, HOLD → 0). It has no combinational path from out_ready.
- The HOLD → IDLE edge needs out_ready=1. A new window can then start on the very next cycle.
- acc_in, in_valid, out_ready and clear are sampled only at rising clk.

## Configuration
- ACC_SATURATE_EN defined:
  - If the final sum exceeds 2^(BITS-1)-1, acc_out = 0x7FFF (for BITS=16).
  - If the final sum is below -2^(BITS-1), acc_out = 0x8000.
  - sat_flag=1 when clamping occurred, otherwise 0.
- ACC_SATURATE_EN undefined:
  - acc_out = sum[BITS-1:0] (two's-complement wrap).
  - sat_flag is tied to 0.
  - No comparator logic is synthesised.

## Test plan
All cases use BITS=16, TRANC=8, TAPS=4.
- Basic sum: beats 0x0100, 0x0080, 0xFF00, 0x0040 back-to-back → acc_out=0x00C0, out_valid the cycle after beat 4, sat_flag=0.
- Bubbles and backpressure:
  - Same data with in_valid low between beats, out_ready held 0 for 5 cycles → acc_out stable at 0x00C0, in_ready=0 throughout HOLD.
  - Then out_ready=1 → IDLE next cycle.
- Saturation: four beats of 0x7000 → with ACC_SATURATE_EN, acc_out=0x7FFF and sat_flag=1; without it, acc_out=0xC000 and sat_flag=0. Four beats of 0x9000 → 0x8000 with sat_flag=1, or 0x4000 wrapped.
- clear:
  - After 2 beats, assert clear together with a third valid beat → busy=0, state IDLE, that beat discarded.
  - Next window 4×0x0100 → acc_out=0x0400.
  - clear asserted during HOLD → acc_out unchanged.
- Async reset: assert rst mid-ACCUM and mid-HOLD, off clock edges → all outputs at reset values immediately.
  - After release, 4×0xFF00 → acc_out=0xFC00.
- Back-to-back windows: out_ready tied 1, continuous in_valid with 8 beats of 0x0010 → two results of 0x0040, one stall cycle between windows.
